// File: rtl/bw_io_jp_bsr_seq.sv
// bw_io_jp_bsr_seq: boundary-scan chain sequencer (capture/shift/update) driven by a command/response handshake.
// All outputs are registered from the next state so strobes line up with the FSM state they belong to.
module bw_io_jp_bsr_seq #(
   parameter int MAXLEN = 64
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [1:0]        cmd_op,
   input  logic [6:0]        cmd_len,
   input  logic [MAXLEN-1:0] cmd_wdata,
   input  logic              abort,
   output logic              rsp_vld,
   input  logic              rsp_rdy,
   output logic [MAXLEN-1:0] rsp_rdata,
   output logic              rsp_abort,
   output logic              bsr_si,
   input  logic              bsr_so,
   output logic              shift_dr,
   output logic              clock_dr,
   output logic              update_dr,
   output logic              mode_ctl
);
   localparam int AW = $clog2(MAXLEN);
   typedef enum logic [2:0] {IDLE, CAPT, SSET, SCLK, UPD, RESP} state_t;
   state_t state_q, state_d;
   logic [6:0] len_q, len_d, bitcnt_q, bitcnt_d, lim;
   logic [MAXLEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic abt_q, abt_d, acc, kill;
   logic cmd_rdy_q, rsp_vld_q, si_q, shift_q, clock_q, update_q, mode_q;
   assign acc  = cmd_vld & cmd_rdy_q & (state_q == IDLE);
   assign kill = abort & (state_q inside {CAPT, SSET, SCLK});
   assign lim  = (len_q == 7'd0) ? 7'(MAXLEN) : len_q;
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      bitcnt_d = bitcnt_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      abt_d    = abt_q;
      case (state_q)
         IDLE: if (acc) begin
            wdata_d  = cmd_wdata;
            len_d    = cmd_len;
            rdata_d  = '0;
            bitcnt_d = '0;
            abt_d    = 1'b0;
            state_d  = (cmd_op == 2'b00) ? CAPT : (cmd_op == 2'b01) ? SSET : (cmd_op == 2'b10) ? UPD : RESP;
         end
         CAPT: state_d = SSET;
         SSET: begin
            rdata_d[bitcnt_q[AW-1:0]] = bsr_so;
            state_d = SCLK;
         end
         SCLK: begin
            bitcnt_d = bitcnt_q + 7'd1;
            state_d  = (bitcnt_q + 7'd1 < lim) ? SSET : UPD;
         end
         UPD:  state_d = RESP;
         RESP: if (rsp_vld_q & rsp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort beats the SCLK->UPD step so update_dr never fires on an aborted command.
      if (kill) begin
         state_d = RESP;
         abt_d   = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
         len_q     <= '0;
         bitcnt_q  <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         abt_q     <= 1'b0;
         cmd_rdy_q <= 1'b0;
         rsp_vld_q <= 1'b0;
         si_q      <= 1'b0;
         shift_q   <= 1'b0;
         clock_q   <= 1'b0;
         update_q  <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         len_q     <= len_d;
         bitcnt_q  <= bitcnt_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         abt_q     <= abt_d;
         cmd_rdy_q <= state_d == IDLE;
         rsp_vld_q <= state_d == RESP;
         si_q      <= (state_d == SSET) ? wdata_d[bitcnt_d[AW-1:0]] : (state_d == SCLK) & si_q;
         shift_q   <= state_d inside {SSET, SCLK};
         clock_q   <= state_d inside {CAPT, SCLK};
         update_q  <= state_d == UPD;
         mode_q    <= (acc && cmd_op == 2'b11) ? cmd_wdata[0] : mode_q;
      end
   assign cmd_rdy   = cmd_rdy_q;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = rdata_q;
   assign rsp_abort = abt_q;
   assign bsr_si    = si_q;
   assign shift_dr  = shift_q;
   assign clock_dr  = clock_q;
   assign update_dr = update_q;
   assign mode_ctl  = mode_q;
endmodule

// File: doc/bw_io_jp_bsr_seq.md
BW_IO_JP_BSR_SEQ -- requirements
Module: bw_io_jp_bsr_seq

Interface
REQ-001 The block SHALL have the parameter MAXLEN, default 64, giving the maximum boundary-scan chain length in bits.
REQ-002 clk  in  1  the single block clock; every output is registered on the rising edge of clk.
REQ-003 rst_l  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_vld  in  1  command valid.
REQ-005 cmd_rdy  out  1  command ready; high only in IDLE.
REQ-006 cmd_op  in  2  command opcode: 00=CSU (capture-shift-update), 01=SHIFT (shift-update, no capture), 10=UPD (update only), 11=MODE (load mode_ctl).
REQ-007 cmd_len  in  7  number of bits to shift, valid range 1..MAXLEN; 0 SHALL be treated as MAXLEN.
REQ-008 cmd_wdata  in  MAXLEN  shift-in data, bit 0 shifted first; for MODE only bit 0 is used.
REQ-009 abort  in  1  synchronous abort of the command in flight.
REQ-010 rsp_vld  out  1  response valid.
REQ-011 rsp_rdy  in  1  response accept.
REQ-012 rsp_rdata  out  MAXLEN  captured chain data, first bit out in bit 0.
REQ-013 rsp_abort  out  1  the response ends an aborted command.
REQ-014 bsr_si  out  1  serial data to the head of the chain.
REQ-015 bsr_so  in  1  serial data from the tail of the chain.
REQ-016 shift_dr, clock_dr, update_dr  out  1 each  chain controls.
REQ-017 mode_ctl  out  1  chain mode control, held between commands.

Function
REQ-018 The FSM SHALL have the states IDLE, CAPT, SSET, SCLK, UPD and RESP.
REQ-019 A command SHALL be accepted on a cycle with cmd_vld&cmd_rdy; on that cycle cmd_wdata, cmd_len and cmd_op are latched, and cmd_rdy drops on the next cycle.
REQ-020 IDLE SHALL transition by opcode: CSU->CAPT; SHIFT->SSET; UPD->UPD; MODE->RESP, with mode_ctl<=cmd_wdata[0] on the same edge.
REQ-021 CAPT SHALL last one cycle with shift_dr=0 and clock_dr=1, then go to SSET.
REQ-022 SSET SHALL last one cycle: shift_dr=1, clock_dr=0, bsr_si=wdata[bitcnt], and rdata[bitcnt]<=bsr_so at the end of the cycle; then go to SCLK.
REQ-023 SCLK SHALL last one cycle: shift_dr=1, clock_dr=1, and bsr_si held; bitcnt increments; the next state is SSET if bitcnt+1<len, otherwise UPD.
REQ-024 UPD SHALL last one cycle with update_dr=1, shift_dr=0 and clock_dr=0, then go to RESP.
REQ-025 RESP SHALL drive rsp_vld=1 with rsp_rdata and rsp_abort stable, hold them until rsp_rdy, and return to IDLE on the rsp_vld&rsp_rdy cycle.
REQ-026 The chain strobes SHALL be mutually exclusive: update_dr never high with shift_dr or clock_dr, and at most one clock_dr pulse per SCLK/CAPT state.
REQ-027 Latency from the accept edge to the first rsp_vld cycle SHALL be: CSU 2N+3 cycles, SHIFT 2N+2, UPD 2, MODE 1.
REQ-028 rsp_rdata bits at index >= len SHALL be 0; for UPD and MODE all of rsp_rdata SHALL be 0.
REQ-029 bitcnt SHALL be 7 bits wide, cleared on accept; a len of MAXLEN SHALL terminate with no wrap-around.
REQ-030 abort asserted in CAPT, SSET or SCLK SHALL take the FSM to RESP on the next edge with rsp_abort=1, skipping UPD so that update_dr never pulses.
REQ-031 The partial rdata captured before an abort SHALL be returned.
REQ-032 abort in IDLE, UPD or RESP SHALL be ignored.
REQ-033 If abort is asserted in the same cycle as an SCLK->UPD transition, abort SHALL win.
REQ-034 cmd_vld while not in IDLE SHALL be ignored; upstream holds the command until cmd_rdy.
REQ-035 bsr_si SHALL be 0 whenever shift_dr=0.

Reset
REQ-036 While rst_l=0 the block SHALL force: FSM=IDLE, cmd_rdy=0, rsp_vld=0, rsp_abort=0, rsp_rdata=0, shift_dr=0, clock_dr=0, update_dr=0, bsr_si=0, mode_ctl=0, bitcnt=0.
REQ-037 cmd_rdy SHALL go to 1 on the first clk edge after rst_l deasserts.
REQ-038 Reset asserted mid-command SHALL deassert all strobes immediately (asynchronously), with no response issued after reset.

Verification
REQ-039 CSU, len=4, wdata=0xA, 8-bit chain model preloaded 0x5C -> one capture pulse, bsr_si sequence 0,1,0,1, 4 clock_dr shift pulses, 1 update_dr pulse, rsp_vld 11 cycles after accept, rsp_rdata=capture-dependent low 4 bits, upper bits 0.
REQ-040 SHIFT, len=0 (=64), wdata=0xFFFF_0000_1234_5678, 64-bit chain model -> 64 clock_dr pulses, no capture, rsp_rdata=prior chain contents, rsp_vld 130 cycles after accept.
REQ-041 MODE, wdata[0]=1, then UPD -> mode_ctl=1 one cycle after accept and held; UPD gives update_dr pulse, rsp_vld 2 cycles after accept, rsp_rdata=0.
REQ-042 CSU, len=8, abort at the 3rd SCLK -> rsp_abort=1, rdata[2:0] valid, rdata[63:3]=0, zero update_dr pulses.
REQ-043 rsp_rdy held low 5 cycles, cmd_vld high throughout -> rsp stable, no second accept until the rsp handshake, cmd_rdy high the following cycle.
REQ-044 rst_l low during SCLK of a CSU -> all strobes 0 asynchronously, mode_ctl=0, and no rsp_vld after release.
